// File: rtl/mux_arbiter_2to1_if.sv
// Bus bundle between the two requesters and the 2:1 operand/address arbiter.
// Optional macro ARB_PERF_CNT_EN adds the performance-counter outputs.
interface mux_arbiter_2to1_if #(
  parameter int unsigned WIDTH = 24
);
  localparam int unsigned PERF_W = 16;

  logic             Req0;
  logic             Req1;
  logic             Done0;
  logic             Done1;
  logic [WIDTH-1:0] Hyrja0;
  logic [WIDTH-1:0] Hyrja1;
  logic             Gnt0;
  logic             Gnt1;
  logic             S;
  logic [WIDTH-1:0] Dalja;
  logic             Busy;
`ifdef ARB_PERF_CNT_EN
  logic [PERF_W-1:0] PerfGnt0;
  logic [PERF_W-1:0] PerfGnt1;
  logic [PERF_W-1:0] PerfConflict;
`endif

`ifdef ARB_PERF_CNT_EN
  // Requester side: drives requests, releases and data; observes grants.
  modport master (
    output Req0, Req1, Done0, Done1, Hyrja0, Hyrja1,
    input  Gnt0, Gnt1, S, Dalja, Busy, PerfGnt0, PerfGnt1, PerfConflict
  );
  // Arbiter side.
  modport slave (
    input  Req0, Req1, Done0, Done1, Hyrja0, Hyrja1,
    output Gnt0, Gnt1, S, Dalja, Busy, PerfGnt0, PerfGnt1, PerfConflict
  );
`else
  // Requester side: drives requests, releases and data; observes grants.
  modport master (
    output Req0, Req1, Done0, Done1, Hyrja0, Hyrja1,
    input  Gnt0, Gnt1, S, Dalja, Busy
  );
  // Arbiter side.
  modport slave (
    input  Req0, Req1, Done0, Done1, Hyrja0, Hyrja1,
    output Gnt0, Gnt1, S, Dalja, Busy
  );
`endif
endinterface

// File: rtl/mux_arbiter_2to1.sv
// Round-robin arbiter with bounded hold time that owns the select of the
// shared 2:1 operand/address mux (requester 0 = fetch, 1 = load/store).
// Optional macro ARB_PERF_CNT_EN adds saturating grant/conflict counters.
module mux_arbiter_2to1 #(
  parameter int unsigned WIDTH    = 24,
  parameter int unsigned HOLD_MAX = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic Clock,
  input  logic Reset,
  mux_arbiter_2to1_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_G0   = 2'b01;
  localparam logic [1:0] ST_G1   = 2'b10;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);
  localparam logic [WIDTH-1:0] DATA_ZERO = '0;

  logic [1:0]       state_q;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             last_q;     // 1: requester 1 was granted most recently
  logic             last_nxt;
  logic             gnt0_q;
  logic             gnt1_q;
  logic             s_q;
  logic             busy_q;

  // State, hold counter, round-robin pointer and registered grant outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      s_q     <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      last_q  <= last_nxt;
      gnt0_q  <= (state_nxt == ST_G0);
      gnt1_q  <= (state_nxt == ST_G1);
      s_q     <= (state_nxt == ST_G0);
      busy_q  <= (state_nxt != ST_IDLE);
    end
  end

  // Next-state: arbitration in IDLE, release/handoff/forced switch when granted.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    last_nxt  = last_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (bus.Req0 && bus.Req1) begin
          state_nxt = last_q ? ST_G0 : ST_G1;
        end else if (bus.Req0) begin
          state_nxt = ST_G0;
        end else if (bus.Req1) begin
          state_nxt = ST_G1;
        end
      end

      ST_G0: begin
        if (bus.Done0 || !bus.Req0) begin
          state_nxt = bus.Req1 ? ST_G1 : ST_IDLE;
        end else if (bus.Req1 && (cnt_q == HOLD_LAST)) begin
          state_nxt = ST_G1;
        end else if (bus.Req1) begin
          cnt_nxt = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end

      ST_G1: begin
        if (bus.Done1 || !bus.Req1) begin
          state_nxt = bus.Req0 ? ST_G0 : ST_IDLE;
        end else if (bus.Req0 && (cnt_q == HOLD_LAST)) begin
          state_nxt = ST_G0;
        end else if (bus.Req0) begin
          cnt_nxt = (cnt_q == HOLD_LAST) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
          cnt_nxt = '0;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
        cnt_nxt   = '0;
      end
    endcase

    // Any grant change restarts the hold window and moves the round-robin pointer.
    if (state_nxt != state_q) begin
      cnt_nxt = '0;
      if (state_nxt == ST_G0) begin
        last_nxt = 1'b0;
      end else if (state_nxt == ST_G1) begin
        last_nxt = 1'b1;
      end
    end
  end

  assign bus.Gnt0  = gnt0_q;
  assign bus.Gnt1  = gnt1_q;
  assign bus.S     = s_q;
  assign bus.Busy  = busy_q;
  // Data follows the registered grant, so it never shows an ungranted requester.
  assign bus.Dalja = gnt0_q ? bus.Hyrja0 : (gnt1_q ? bus.Hyrja1 : DATA_ZERO);

`ifdef ARB_PERF_CNT_EN
  localparam int unsigned       PERF_W   = 16;
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [PERF_W-1:0] perf_gnt0_q;
  logic [PERF_W-1:0] perf_gnt1_q;
  logic [PERF_W-1:0] perf_conf_q;
  logic              conflict;

  assign conflict = (bus.Req0 && !gnt0_q) || (bus.Req1 && !gnt1_q);

  // Saturating occupancy and waiting-requester counters.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      perf_gnt0_q <= '0;
      perf_gnt1_q <= '0;
      perf_conf_q <= '0;
    end else begin
      if (gnt0_q && (perf_gnt0_q != PERF_MAX)) begin
        perf_gnt0_q <= perf_gnt0_q + PERF_W'(1);
      end
      if (gnt1_q && (perf_gnt1_q != PERF_MAX)) begin
        perf_gnt1_q <= perf_gnt1_q + PERF_W'(1);
      end
      if (conflict && (perf_conf_q != PERF_MAX)) begin
        perf_conf_q <= perf_conf_q + PERF_W'(1);
      end
    end
  end

  assign bus.PerfGnt0     = perf_gnt0_q;
  assign bus.PerfGnt1     = perf_gnt1_q;
  assign bus.PerfConflict = perf_conf_q;
`endif

  // Grants are mutually exclusive.
  gnt_mutex_a: assert property (@(posedge Clock) disable iff (Reset) !(gnt0_q && gnt1_q));

endmodule

// File: tb/tb_mux_arbiter_2to1.sv
// Directed, table-driven bench for mux_arbiter_2to1 (HOLD_MAX=4).
module tb_mux_arbiter_2to1;

  localparam int unsigned WIDTH = 24;
  localparam int unsigned NVEC  = 31;

  logic Clock = 1'b0;
  logic Reset;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 Clock = ~Clock;

  mux_arbiter_2to1_if #(.WIDTH(WIDTH)) bus ();

  mux_arbiter_2to1 #(.WIDTH(WIDTH), .HOLD_MAX(4), .CNT_W(3)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus  (bus)
  );

  typedef struct {
    logic rst, r0, r1, d0, d1;
    logic g0, g1, s, busy;
  } vec_t;

  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic rst, input logic r0, input logic r1,
                              input logic d0, input logic d1, input logic g0,
                              input logic g1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.r1 = r1; v.d0 = d0; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.s = g0; v.busy = g0 | g1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic r0, input logic r1,
                       input logic d0, input logic d1);
    Reset = rst; bus.Req0 = r0; bus.Req1 = r1; bus.Done0 = d0; bus.Done1 = d1;
  endtask

  // Clock one edge, then compare all outputs against the expected grant.
  task automatic step_check(input string name, input logic g0, input logic g1);
    logic [WIDTH-1:0] exp_d;
    @(posedge Clock);
    #1;
    exp_d = g0 ? bus.Hyrja0 : (g1 ? bus.Hyrja1 : '0);
    check({name, " gnt0"},  32'(bus.Gnt0),  32'(g0));
    check({name, " gnt1"},  32'(bus.Gnt1),  32'(g1));
    check({name, " s"},     32'(bus.S),     32'(g0));
    check({name, " busy"},  32'(bus.Busy),  32'(g0 | g1));
    check({name, " dalja"}, 32'(bus.Dalja), 32'(exp_d));
  endtask

  // Grant overlap monitor.
  always @(negedge Clock) begin
    if (Reset === 1'b0) begin
      n_cmp++;
      if (bus.Gnt0 && bus.Gnt1) begin
        n_err++;
        $display("FAIL grant overlap: gnt0=%b gnt1=%b required not both 1", bus.Gnt0, bus.Gnt1);
      end
    end
  end

  initial begin
    //            rst r0 r1 d0 d1   g0 g1
    vecs[0]  = mk(1, 1, 1, 0, 0,   0, 0);  // reset held with both requesting
    vecs[1]  = mk(1, 1, 1, 0, 0,   0, 0);
    vecs[2]  = mk(1, 1, 1, 0, 0,   0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 0,   1, 0);  // tie -> requester 0 first
    vecs[4]  = mk(0, 1, 1, 0, 0,   1, 0);
    vecs[5]  = mk(0, 1, 1, 0, 0,   1, 0);
    vecs[6]  = mk(0, 1, 1, 0, 0,   1, 0);
    vecs[7]  = mk(0, 1, 1, 0, 0,   0, 1);  // forced switch after 4 cycles
    vecs[8]  = mk(0, 1, 1, 0, 0,   0, 1);
    vecs[9]  = mk(0, 1, 1, 0, 0,   0, 1);
    vecs[10] = mk(0, 1, 1, 0, 0,   0, 1);
    vecs[11] = mk(0, 1, 1, 0, 0,   1, 0);
    vecs[12] = mk(0, 1, 0, 0, 0,   1, 0);
    vecs[13] = mk(0, 1, 0, 0, 0,   1, 0);
    vecs[14] = mk(0, 1, 1, 0, 0,   1, 0);  // Req1 rises
    vecs[15] = mk(0, 1, 1, 0, 0,   1, 0);
    vecs[16] = mk(0, 1, 1, 1, 0,   0, 1);  // Done0 -> handoff, no bubble
    vecs[17] = mk(0, 0, 1, 0, 0,   0, 1);
    vecs[18] = mk(0, 0, 1, 0, 1,   0, 0);  // Done1 -> IDLE
    vecs[19] = mk(0, 0, 0, 0, 0,   0, 0);
    vecs[20] = mk(0, 0, 1, 0, 0,   0, 1);  // lone Req1
    vecs[21] = mk(0, 0, 1, 0, 1,   0, 0);
    vecs[22] = mk(0, 0, 1, 0, 0,   0, 1);
    vecs[23] = mk(0, 0, 1, 0, 1,   0, 0);  // Done with Req still high: release wins
    vecs[24] = mk(0, 0, 1, 0, 0,   0, 1);  // re-arbitrated
    vecs[25] = mk(0, 0, 1, 1, 0,   0, 1);  // Done0 ignored while G1
    vecs[26] = mk(0, 0, 0, 0, 0,   0, 0);  // Req1 drop releases
    vecs[27] = mk(0, 1, 1, 0, 0,   1, 0);  // last=1 -> requester 0
    vecs[28] = mk(0, 0, 0, 0, 0,   0, 0);
    vecs[29] = mk(0, 1, 1, 0, 0,   0, 1);  // last=0 -> requester 1
    vecs[30] = mk(0, 0, 0, 0, 0,   0, 0);

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.Hyrja0 = 24'hABCDEF;
    bus.Hyrja1 = 24'h123456;

    for (int i = 0; i < int'(NVEC); i++) begin
      drive(vecs[i].rst, vecs[i].r0, vecs[i].r1, vecs[i].d0, vecs[i].d1);
      bus.Hyrja0 = 24'hABCDEF ^ 24'(i);
      bus.Hyrja1 = 24'h123456 + 24'(i);
      step_check($sformatf("row%0d", i), vecs[i].g0, vecs[i].g1);
    end

    // Lone requester holds indefinitely without contention.
    bus.Hyrja0 = 24'hABCDEF;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      step_check($sformatf("lone0_%0d", k), 1'b1, 1'b0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_check("lone0_end", 1'b0, 1'b0);

    // Reset during G1 with hold count 2.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step_check("mid_g1", 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step_check("mid_cnt1", 1'b0, 1'b1);
    step_check("mid_cnt2", 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step_check("mid_rst", 1'b0, 1'b0);
`ifdef ARB_PERF_CNT_EN
    check("perf_gnt0 rst", 32'(bus.PerfGnt0), 32'd0);
    check("perf_gnt1 rst", 32'(bus.PerfGnt1), 32'd0);
    check("perf_conf rst", 32'(bus.PerfConflict), 32'd0);
`endif
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step_check("post_rst0", 1'b1, 1'b0);
    step_check("post_rst1", 1'b1, 1'b0);
    step_check("post_rst2", 1'b1, 1'b0);
    step_check("post_rst3", 1'b1, 1'b0);
    step_check("post_rst4", 1'b0, 1'b1);
`ifdef ARB_PERF_CNT_EN
    // Gnt0 high for 4 sampled edges; one requester waited on every edge since.
    check("perf_gnt0 run", 32'(bus.PerfGnt0), 32'd4);
    check("perf_conf run", 32'(bus.PerfConflict), 32'd5);
`endif

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step_check("final_idle", 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
